// File: rtl/reu_xfer_ctrl.sv
// REU transfer controller: arms on a command, takes the C64 bus via DMA and
// sequences byte cycles, length counting, autoload and status flags.
module reu_xfer_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             PHI2,
  input  logic             nRESET,
  input  logic             Execute,
  input  logic             Immediate,
  input  logic             FF00Wr,
  input  logic             BA,
  input  logic [1:0]       XferType,
  input  logic             Autoload,
  input  logic             LenLoad,
  input  logic [LEN_W-1:0] LenIn,
  input  logic             Equal,
  input  logic             StatusRd,
  output logic             DMA,
  output logic             DMARW,
  output logic             RAMRD,
  output logic             RAMWR,
  output logic             NextCA,
  output logic             NextREUA,
  output logic             ExecClr,
  output logic             RegReset,
  output logic             XferEnd,
  output logic             VerifyErr,
  output logic [LEN_W-1:0] LenCnt
);

  localparam logic [1:0] XT_C64_TO_REU = 2'b00;
  localparam logic [1:0] XT_REU_TO_C64 = 2'b01;
  localparam logic [1:0] XT_SWAP       = 2'b10;
  localparam logic [1:0] XT_VERIFY     = 2'b11;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_XFER,
    S_SWAPB,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] len_cnt_reg;
  logic [LEN_W-1:0] len_copy_reg;
  logic             xfer_end_reg;
  logic             verify_err_reg;

  logic advance;
  logic last_byte;
  logic verify_fail;
  logic start_entry;
  logic len_load_ok;

  // A byte "advances" when both address counters step; that is also the
  // only cycle the length counter moves and termination is evaluated.
  assign advance = BA && ((state_reg == S_XFER && XferType != XT_SWAP) ||
                          state_reg == S_SWAPB);
  assign last_byte   = (len_cnt_reg == LEN_ONE);
  assign verify_fail = BA && state_reg == S_XFER && XferType == XT_VERIFY && !Equal;
  assign start_entry = Execute && ((state_reg == S_IDLE && Immediate) ||
                                   (state_reg == S_ARMED && FF00Wr));
  assign len_load_ok = LenLoad && (state_reg == S_IDLE || state_reg == S_ARMED);

  always_comb begin
    DMARW    = 1'b1;
    RAMRD    = 1'b0;
    RAMWR    = 1'b0;
    NextCA   = 1'b0;
    NextREUA = 1'b0;
    if (state_reg == S_XFER && BA) begin
      case (XferType)
        XT_C64_TO_REU: begin
          RAMWR    = 1'b1;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
        end
        XT_REU_TO_C64: begin
          DMARW    = 1'b0;
          RAMRD    = 1'b1;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
        end
        XT_SWAP: begin
          // First half of a swap: latch both bytes, addresses stay put.
          RAMRD = 1'b1;
        end
        default: begin
          RAMRD    = 1'b1;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
        end
      endcase
    end else if (state_reg == S_SWAPB && BA) begin
      DMARW    = 1'b0;
      RAMWR    = 1'b1;
      NextCA   = 1'b1;
      NextREUA = 1'b1;
    end
  end

  assign DMA       = (state_reg == S_START) || (state_reg == S_XFER) || (state_reg == S_SWAPB);
  assign ExecClr   = (state_reg == S_DONE);
  assign RegReset  = (state_reg == S_DONE) && Autoload;
  assign XferEnd   = xfer_end_reg;
  assign VerifyErr = verify_err_reg;
  assign LenCnt    = len_cnt_reg;

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Execute) state_reg <= Immediate ? S_START : S_ARMED;
        end
        S_ARMED: begin
          // A cancelled command takes precedence over a trigger in the same cycle.
          if (!Execute)    state_reg <= S_IDLE;
          else if (FF00Wr) state_reg <= S_START;
        end
        S_START: state_reg <= S_XFER;
        S_XFER: begin
          if (BA) begin
            if (XferType == XT_SWAP)              state_reg <= S_SWAPB;
            else if (last_byte || verify_fail)    state_reg <= S_DONE;
          end
        end
        S_SWAPB: begin
          if (BA) state_reg <= last_byte ? S_DONE : S_XFER;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      len_cnt_reg  <= LEN_ONES;
      len_copy_reg <= LEN_ONES;
    end else if (state_reg == S_DONE && Autoload) begin
      len_cnt_reg <= len_copy_reg;
    end else if (advance) begin
      // Wraps modulo 2^LEN_W, so a loaded 0 yields a full 2^LEN_W block.
      len_cnt_reg <= len_cnt_reg - LEN_ONE;
    end else if (len_load_ok) begin
      len_cnt_reg  <= LenIn;
      len_copy_reg <= LenIn;
    end
  end

  // Set events win over a coincident status read.
  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      xfer_end_reg   <= 1'b0;
      verify_err_reg <= 1'b0;
    end else begin
      if (advance && last_byte)          xfer_end_reg <= 1'b1;
      else if (StatusRd || start_entry)  xfer_end_reg <= 1'b0;

      if (verify_fail)                   verify_err_reg <= 1'b1;
      else if (StatusRd || start_entry)  verify_err_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reu_xfer_ctrl.sv
// Self-checking bench for reu_xfer_ctrl: directed and randomized transfers
// compared against a transfer-level model of expected strobe counts and flags.
module tb_reu_xfer_ctrl;

  localparam int LEN_W = 16;
  localparam int FULL  = 1 << LEN_W;
  localparam int MASK  = FULL - 1;

  logic             PHI2 = 1'b1;
  logic             nRESET = 1'b0;
  logic             Execute = 1'b0;
  logic             Immediate = 1'b0;
  logic             FF00Wr = 1'b0;
  logic             BA = 1'b1;
  logic [1:0]       XferType = 2'b00;
  logic             Autoload = 1'b0;
  logic             LenLoad = 1'b0;
  logic [LEN_W-1:0] LenIn = '0;
  logic             Equal = 1'b1;
  logic             StatusRd = 1'b0;
  logic             DMA, DMARW, RAMRD, RAMWR, NextCA, NextREUA;
  logic             ExecClr, RegReset, XferEnd, VerifyErr;
  logic [LEN_W-1:0] LenCnt;

  int checks = 0;
  int failures = 0;

  reu_xfer_ctrl #(.LEN_W(LEN_W)) dut (
    .PHI2(PHI2), .nRESET(nRESET), .Execute(Execute), .Immediate(Immediate),
    .FF00Wr(FF00Wr), .BA(BA), .XferType(XferType), .Autoload(Autoload),
    .LenLoad(LenLoad), .LenIn(LenIn), .Equal(Equal), .StatusRd(StatusRd),
    .DMA(DMA), .DMARW(DMARW), .RAMRD(RAMRD), .RAMWR(RAMWR), .NextCA(NextCA),
    .NextREUA(NextREUA), .ExecClr(ExecClr), .RegReset(RegReset),
    .XferEnd(XferEnd), .VerifyErr(VerifyErr), .LenCnt(LenCnt)
  );

  always #5 PHI2 = ~PHI2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; state moves on the falling edge.
  task automatic next_cyc();
    @(posedge PHI2);
    #1;
  endtask

  task automatic run_xfer(input int typ, input int len, input bit imm, input bit al,
                          input int mism, input int stall_pct, input bit rd_during,
                          input bit junk, input int arm_cycles, input bit clear_after);
    int eff, bytes, per_byte, exp_rd, exp_wr, exp_wlow, exp_len, limit;
    bit exp_verr;
    int rd = 0, wr = 0, nca = 0, nreua = 0, wlow = 0, dma_cyc = 0, stalls = 0;
    int viol = 0, regres = 0, cyc = 0, armed_dma = 0;
    bit first = 1, done = 0, stall, execclr_dma = 0;

    eff      = (len == 0) ? FULL : len;
    exp_verr = (typ == 3) && (mism >= 1) && (mism <= eff);
    bytes    = exp_verr ? mism : eff;
    per_byte = (typ == 2) ? 2 : 1;
    exp_rd   = (typ == 0) ? 0 : bytes;
    exp_wr   = (typ == 0 || typ == 2) ? bytes : 0;
    exp_wlow = (typ == 1 || typ == 2) ? bytes : 0;
    exp_len  = al ? (len & MASK) : (eff - bytes);
    limit    = 2 * eff + 2000;

    XferType = 2'(typ); Autoload = al; Immediate = imm;
    LenIn = LEN_W'(len); LenLoad = 1'b1;
    next_cyc();
    LenLoad = 1'b0; Execute = 1'b1;
    if (!imm) begin
      repeat (arm_cycles) begin
        next_cyc();
        #1 armed_dma += int'(DMA);
      end
      FF00Wr = 1'b1;
    end
    next_cyc();
    FF00Wr = 1'b0;
    if (!imm) check("armed_dma_low", armed_dma, 0);

    while (!done && cyc < limit) begin
      BA = 1'b1; stall = 0;
      if (DMA && !first && $urandom_range(99) < stall_pct) begin
        BA = 1'b0; stall = 1;
      end
      Equal    = (typ == 3) ? ((nca + 1) != mism) : 1'($urandom);
      StatusRd = rd_during && DMA;
      LenLoad  = junk && DMA && ($urandom_range(1) == 1);
      LenIn    = LEN_W'($urandom);
      #1;
      if (first) begin
        check("start_dma", DMA, 1);
        check("start_xferend_clr", XferEnd, 0);
        check("start_verifyerr_clr", VerifyErr, 0);
      end
      if (DMA) dma_cyc++;
      if (stall) begin
        stalls++;
        if (RAMRD || RAMWR || NextCA || NextREUA) viol++;
      end
      rd += int'(RAMRD); wr += int'(RAMWR);
      nca += int'(NextCA); nreua += int'(NextREUA);
      if (DMA && !DMARW) wlow++;
      regres += int'(RegReset);
      if (ExecClr) begin
        done = 1;
        execclr_dma = DMA;
      end
      first = 0;
      cyc++;
      next_cyc();
    end
    BA = 1'b1; StatusRd = 1'b0; LenLoad = 1'b0; Execute = 1'b0;
    #1;
    check("done_reached", done, 1);
    check("nextca_count", nca, bytes);
    check("nextreua_count", nreua, bytes);
    check("ramrd_count", rd, exp_rd);
    check("ramwr_count", wr, exp_wr);
    check("dma_write_cycles", wlow, exp_wlow);
    check("dma_active_cycles", dma_cyc, 1 + per_byte * bytes + stalls);
    check("stall_strobes", viol, 0);
    check("dma_in_done", execclr_dma, 0);
    check("regreset_pulses", regres, al ? 1 : 0);
    check("xferend", XferEnd, (bytes == eff) ? 1 : 0);
    check("verifyerr", VerifyErr, exp_verr ? 1 : 0);
    check("lencnt_after", LenCnt, exp_len);
    check("idle_dma", DMA, 0);
    $display("xfer type=%0d len=%0d imm=%0d al=%0d mism=%0d stalls=%0d bytes=%0d lencnt=%0d xend=%0d verr=%0d",
             typ, len, imm, al, mism, stalls, nca, LenCnt, XferEnd, VerifyErr);
    if (clear_after) begin
      StatusRd = 1'b1;
      next_cyc();
      StatusRd = 1'b0;
      #1;
      check("statusrd_xferend", XferEnd, 0);
      check("statusrd_verifyerr", VerifyErr, 0);
    end
  endtask

  initial begin
    int t, l, m;
    #11;
    check("rst_dma", DMA, 0);
    check("rst_dmarw", DMARW, 1);
    check("rst_strobes", {RAMRD, RAMWR, NextCA, NextREUA, ExecClr, RegReset}, 0);
    check("rst_flags", {XferEnd, VerifyErr}, 0);
    check("rst_lencnt", LenCnt, MASK);
    nRESET = 1'b1;
    next_cyc();

    run_xfer(0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    run_xfer(1, 2, 0, 0, 0, 0, 0, 0, 10, 0);
    run_xfer(2, 2, 1, 0, 0, 40, 0, 0, 0, 1);
    run_xfer(3, 5, 1, 0, 3, 0, 0, 0, 0, 1);
    run_xfer(3, 4, 1, 1, 4, 20, 1, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(3));
      l = int'($urandom_range(1, 12));
      m = (t == 3) ? int'($urandom_range(0, l)) : 0;
      run_xfer(t, l, 1'($urandom), 1'($urandom), m, int'($urandom_range(0, 50)),
               1'($urandom), 1'($urandom), int'($urandom_range(1, 6)), 1'($urandom));
    end

    // Reset in the middle of a transfer with autoload enabled.
    XferType = 2'b00; Immediate = 1'b1; Autoload = 1'b1;
    LenIn = 16'd10; LenLoad = 1'b1;
    next_cyc();
    LenLoad = 1'b0; Execute = 1'b1;
    repeat (4) next_cyc();
    #1 check("midxfer_dma_before", DMA, 1);
    #1 nRESET = 1'b0;
    #1;
    check("midrst_dma", DMA, 0);
    check("midrst_lencnt", LenCnt, MASK);
    check("midrst_regreset", RegReset, 0);
    check("midrst_nextca", NextCA, 0);
    Execute = 1'b0;
    next_cyc();
    nRESET = 1'b1;
    next_cyc();
    #1;
    check("postrst_dma", DMA, 0);
    check("postrst_lencnt", LenCnt, MASK);
    $display("reset mid-xfer dma=%0d lencnt=%0d", DMA, LenCnt);

    // Full-length block with autoload: a loaded 0 means 2^LEN_W bytes.
    run_xfer(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reu_xfer_ctrl.md
Name: reu_xfer_ctrl

Overview:
Transfer controller for the REU CPLD. It arms on a command write, either immediately or on the CPU's $FF00 trigger write. It then takes the C64 bus via DMA and runs one byte cycle per PHI2 cycle for C64-to-REU, REU-to-C64 and verify transfers, and two cycles per byte for swap. It owns the transfer-length counter and its autoload copy, stalls while VIC holds BA low, and reports end-of-block and verify-error status to the register file.

Parameters:
LEN_W, 16, transfer length counter width; a loaded value of 0 means 2^LEN_W bytes.

Ports:
PHI2  in  1  system clock; all state updates on falling edge
nRESET  in  1  asynchronous active-low reset
Execute  in  1  command register execute bit
Immediate  in  1  1 = start at once, 0 = wait for FF00Wr
FF00Wr  in  1  one-cycle pulse: CPU write to $FF00 decoded
BA  in  1  C64 bus available; 0 = VIC steal, stall
XferType  in  2  00 C64->REU, 01 REU->C64, 10 swap, 11 verify
Autoload  in  1  command autoload bit
LenLoad  in  1  CPU write to length register (pulse)
LenIn  in  LEN_W  length value written by CPU
Equal  in  1  verify comparator result, valid in verify byte cycle
StatusRd  in  1  CPU read of status register (clears VerifyErr)
DMA  out  1  request/hold C64 bus
DMARW  out  1  1 = DMA reads C64, 0 = DMA writes C64
RAMRD  out  1  REU DRAM read strobe this cycle
RAMWR  out  1  REU DRAM write strobe this cycle
NextCA  out  1  advance C64 address this cycle
NextREUA  out  1  advance REU address this cycle
ExecClr  out  1  one-cycle pulse: clear Execute bit
RegReset  out  1  one-cycle pulse: reload address registers (autoload)
XferEnd  out  1  sticky end-of-block flag
VerifyErr  out  1  sticky verify-error flag
LenCnt  out  LEN_W  current length counter, for readback

Behaviour:
- Reset (async, nRESET=0): state IDLE; DMA=0, DMARW=1, RAMRD=RAMWR=NextCA=NextREUA=ExecClr=RegReset=0, XferEnd=VerifyErr=0, LenCnt and autoload copy = all ones. Reset mid-transfer releases DMA immediately and performs no autoload.
- LenLoad is accepted only in IDLE or ARMED. It loads both LenCnt and the autoload copy from LenIn. It is ignored in the other states.
- States: IDLE, ARMED, START, XFER, SWAPB, DONE.
- IDLE: on Execute=1, go to START if Immediate=1, else to ARMED. XferEnd and VerifyErr are cleared on entry to START.
- ARMED: wait for FF00Wr=1, then START. Execute falling to 0 returns to IDLE.
- START: DMA=1, no strobes for one settle cycle, then XFER.
- XFER, with BA=0: DMA stays 1, all strobes 0, state and counter held. The stall is unbounded.
- XFER, with BA=1:
  - 00: DMARW=1, RAMWR=1, NextCA=1, NextREUA=1, LenCnt decrements.
  - 01: DMARW=0, RAMRD=1, NextCA=1, NextREUA=1, LenCnt decrements.
  - 10: DMARW=1, RAMRD=1 (both bytes latched), no advance; go to SWAPB.
  - 11: DMARW=1, RAMRD=1, NextCA=1, NextREUA=1, LenCnt decrements. Equal is sampled this edge; Equal=0 sets VerifyErr.
- SWAPB, with BA=1: DMARW=0, RAMWR=1, NextCA=1, NextREUA=1, LenCnt decrements, return to XFER. With BA=0 it holds, like XFER.
- Termination is checked on the advancing cycle:
  - LenCnt==1 before the decrement: set XferEnd, go to DONE.
  - Verify mismatch: go to DONE after that byte has advanced. XferEnd is set only if it was also the last byte.
- Length wrap: LenCnt decrements modulo 2^LEN_W. A loaded 0 therefore transfers 2^LEN_W bytes.
- DONE (one cycle):
  - DMA=0 and ExecClr=1.
  - If Autoload=1: RegReset=1 and LenCnt reloads from the autoload copy.
  - Then IDLE.
- VerifyErr clears on StatusRd. XferEnd clears on StatusRd or on the next START. If StatusRd coincides with a set event, the set wins.
- Strobes are combinational from state, XferType and BA, and are valid for the whole cycle.

Test Plan:
- C64->REU, Immediate=1, LenIn=3, BA=1: START, then 3 cycles of RAMWR/NextCA/NextREUA; XferEnd=1; DMA low after 5 edges; ExecClr pulse; LenCnt=0.
- REU->C64, Immediate=0, LenIn=2: stays ARMED with DMA=0 for 10 cycles; FF00Wr pulse starts it; 2 cycles with DMARW=0 and RAMRD; XferEnd=1.
- Swap, LenIn=2, with BA=0 for 3 cycles during the second SWAPB: 4 active cycles plus 3 stall cycles with no strobes; NextCA pulses exactly 2; DMA held throughout.
- Verify, LenIn=5, Equal=0 on byte 3: VerifyErr=1, stops after 3 advances, LenCnt=2, XferEnd=0; StatusRd clears VerifyErr.
- Autoload=1, LenIn=0: 65536 advances; RegReset pulse in DONE; LenCnt=0 afterwards.
- nRESET low mid-XFER: DMA=0 immediately, LenCnt=all ones, no RegReset.
